mips_cpu_bus_arbiter: RTL and testbench

Shares the CPU's single memory bus between the instruction-fetch unit and the load/store unit. Sits between the CPU core and the external bus port of `mips_cpu_bus`, and sequences each access through the bus read/write/waitrequest handshake. Returns read data to the winning requester and counts bus stall cycles.

---
 rtl/mips_cpu_bus_arbiter_pkg.sv | 18 +
 rtl/mips_cpu_bus_arb_pick.sv | 31 +++
 rtl/mips_cpu_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam logic [3:0] BYTEENABLE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// Grant selection between fetch and data requests.
// Macro MIPS_BUS_ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module mips_cpu_bus_arb_pick
  import mips_cpu_bus_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e grant
);

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = GRANT_FETCH;
    if (if_req && d_req) begin
      grant = (last_grant == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
    end else if (d_req) begin
      grant = GRANT_DATA;
    end
  end
`else
  // Fixed priority only needs d_req; the rest is deliberately ignored.
  logic [1:0] pick_unused;
  assign pick_unused = {if_req, last_grant};

  always_comb begin
    grant = d_req ? GRANT_DATA : GRANT_FETCH;
  end
`endif

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one read/write/waitrequest memory bus between fetch and load/store.
// Macro MIPS_BUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration in the picker.
//
// state | meaning
// IDLE  | no access in flight; sample requests and register the grant
// FETCH | instruction read on the bus, waiting for waitrequest=0
// DATA  | load or store on the bus, waiting for waitrequest=0
// RESP  | one-cycle ready pulse to the winner, then back to IDLE
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [31:0] stall_cycles
);

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  grant_e      grant;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] stall_q, stall_d;

  // The bus is word-addressed; byte offsets are dropped.
  logic [3:0] addr_lsb_unused;
  assign addr_lsb_unused = {if_addr[1:0], d_addr[1:0]};

  // last_grant_q is only consumed by the round-robin picker and is pruned otherwise.
  mips_cpu_bus_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    stall_d      = stall_q + {31'd0, (read_q | write_q) & waitrequest};

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          last_grant_d = grant;
          if (grant == GRANT_DATA) begin
            state_d      = DATA;
            address_d    = {d_addr[31:2], 2'b00};
            read_d       = ~d_write;
            write_d      = d_write;
            writedata_d  = d_wdata;
            byteenable_d = d_byteenable;
          end else begin
            state_d      = FETCH;
            address_d    = {if_addr[31:2], 2'b00};
            read_d       = 1'b1;
            write_d      = 1'b0;
            byteenable_d = BYTEENABLE_WORD;
          end
        end
      end
      FETCH: begin
        if (!waitrequest) begin
          state_d    = RESP;
          read_d     = 1'b0;
          if_rdata_d = readdata;
          if_ready_d = 1'b1;
        end
      end
      DATA: begin
        if (!waitrequest) begin
          state_d   = RESP;
          read_d    = 1'b0;
          write_d   = 1'b0;
          d_ready_d = 1'b1;
          if (read_q) d_rdata_d = readdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FETCH;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      stall_q      <= stall_d;
    end
  end

  assign address      = address_q;
  assign read         = read_q;
  assign write        = write_q;
  assign writedata    = writedata_q;
  assign byteenable   = byteenable_q;
  assign if_ready     = if_ready_q;
  assign d_ready      = d_ready_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Self-checking bench for mips_cpu_bus_arbiter: vector table plus ready/data scoreboard.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_write, waitrequest;
  logic [31:0] if_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteenable;
  logic        if_ready, d_ready, read, write;
  logic [31:0] if_rdata, d_rdata, address, writedata, stall_cycles;
  logic [3:0]  byteenable;

  mips_cpu_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_byteenable (d_byteenable),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .address      (address),
    .write        (write),
    .read         (read),
    .waitrequest  (waitrequest),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_d_rdata = 32'd0;
  logic [31:0] stall_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (read || write) check("rw_exclusive", {31'd0, read & write}, 32'd0);
    if (if_ready || d_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {30'd0, if_ready, d_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_which", {30'd0, if_ready, d_ready}, e.is_d ? 32'd1 : 32'd2);
        check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_d_rdata = 32'd0;
    stall_exp = 32'd0;
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(read || write) && cyc < 10);
  endtask

  task automatic do_vec(input vec_t v);
    int lat;
    int n;
    exp_t e;
    @(negedge clk);
    readdata    = v.rdata;
    waitrequest = (v.waits > 0);
    if (v.is_d) begin
      d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_byteenable = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    e.is_d = v.is_d;
    e.data = (v.is_d && v.wr) ? model_d_rdata : v.rdata;
    sb.push_back(e);
    if (v.is_d && !v.wr) model_d_rdata = v.rdata;

    wait_strobe(lat);
    check("strobe_latency", lat, 32'd1);
    check("strobe_read", {31'd0, read}, {31'd0, !(v.is_d && v.wr)});
    check("strobe_write", {31'd0, write}, {31'd0, v.is_d && v.wr});
    check("address", address, v.exp_addr);
    check("byteenable", {28'd0, byteenable}, {28'd0, v.is_d ? v.be : 4'hF});
    if (v.is_d && v.wr) check("writedata", writedata, v.wdata);
    n = 1;
    for (int k = 0; k < v.waits; k++) begin
      @(negedge clk);
      lat++;
      if (read || write) n++;
      check("hold_address", address, v.exp_addr);
    end
    check("strobe_cycles", n, v.waits + 1);
    waitrequest = 1'b0;
    @(negedge clk);
    lat++;
    check("ready_latency", {31'd0, v.is_d ? d_ready : if_ready}, 32'd1);
    check("ready_cycle", lat, v.waits + 2);
    stall_exp = stall_exp + v.waits;
    check("stall_cycles", stall_cycles, stall_exp);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("ready_pulse_end", {30'd0, if_ready, d_ready}, 32'd0);
    check("idle_no_strobe", {30'd0, read, write}, 32'd0);
  endtask

  initial begin
    int   c1;
    int   c2;
    exp_t e;
    logic exp2_d;

    vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h0,    32'h39280000, 0, 32'hBFC00000};
    vecs[1] = '{1'b1, 1'b1, 32'h00000006, 32'hDEADBEEF, 4'b1100, 32'h0BAD0BAD, 3, 32'h00000004};
    vecs[2] = '{1'b1, 1'b0, 32'h00000001, 32'h0,        4'b0001, 32'h00000055, 0, 32'h00000000};
    vecs[3] = '{1'b0, 1'b0, 32'h00400006, 32'h0,        4'h0,    32'h12345678, 2, 32'h00400004};
    vecs[4] = '{1'b1, 1'b1, 32'h00000010, 32'hCAFEF00D, 4'b0011, 32'h0,        0, 32'h00000010};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        4'b1111, 32'hA5A5A5A5, 1, 32'hFFFFFFFC};

    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_byteenable = '0; readdata = '0;
    repeat (2) @(negedge clk);
    check("rst_address", address, 32'd0);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", {28'd0, byteenable}, 32'd0);
    check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_vec(vecs[i]);

    // Reset during a stalled store: no ready may ever appear for it.
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'h13579BDF;
    d_byteenable = 4'hF; waitrequest = 1'b1;
    wait_strobe(c1);
    check("abort_strobe", {31'd0, write}, 32'd1);
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("abort_strobes", {30'd0, read, write}, 32'd0);
    check("abort_stall", stall_cycles, 32'd0);
    check("abort_ready", {30'd0, if_ready, d_ready}, 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    model_d_rdata = 32'd0; stall_exp = 32'd0;
    repeat (4) @(negedge clk);
    do_vec(vecs[0]);

    // Simultaneous requests held for two rounds.
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h00001000;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h00002000; d_byteenable = 4'hF;
    readdata = 32'h00000077; waitrequest = 1'b0;
    e.is_d = 1'b1; e.data = 32'h77; sb.push_back(e);
    wait_strobe(c1);
    check("sim_round1_addr", address, 32'h00002000);
    @(negedge clk);
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
    exp2_d = 1'b0;
`else
    exp2_d = 1'b1;
`endif
    e.is_d = exp2_d; e.data = 32'h77; sb.push_back(e);
    wait_strobe(c2);
    check("sim_spacing", c2 + 1, 32'd3);
    check("sim_round2_addr", address, exp2_d ? 32'h00002000 : 32'h00001000);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back fetches with if_req held through if_ready.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h00000100; readdata = 32'h00000011;
    e.is_d = 1'b0; e.data = 32'h11; sb.push_back(e); sb.push_back(e);
    wait_strobe(c1);
    @(negedge clk);
    check("b2b_first_ready", {31'd0, if_ready}, 32'd1);
    wait_strobe(c2);
    check("b2b_spacing", c2 + 1, 32'd3);
    @(negedge clk);
    check("b2b_second_ready", {31'd0, if_ready}, 32'd1);
    if_req = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
